// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing a byte-wide instruction memory between a fetch
// port (word reads) and a loader port (word writes), four little-endian beats per word.
module imem_port_arbiter #(
    parameter int unsigned N  = 32,
    parameter int unsigned A  = 32,
    parameter int unsigned AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [A-1:0]  fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_rvalid,
    output logic [N-1:0]  fetch_rdata,
    input  logic          load_req,
    input  logic [A-1:0]  load_addr,
    input  logic [N-1:0]  load_wdata,
    output logic          load_gnt,
    output logic          load_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q;
    logic          prio_load;
    logic          unused_addr_bits;

    // Only the low AW address bits reach the array.
    assign unused_addr_bits = ^{fetch_addr[A-1:AW], load_addr[A-1:AW]};

    // Next-state, grants and memory-side drive.
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (load_req && (!fetch_req || prio_load)) begin
                        load_gnt  = 1'b1;
                        state_nxt = LOAD;
                    end else if (fetch_req) begin
                        fetch_gnt = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                mem_addr = addr_q + AW'(cnt);
                if (cnt == 2'd3) state_nxt = IDLE;
            end
            LOAD: begin
                mem_addr  = addr_q + AW'(cnt);
                mem_we    = 1'b1;
                mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
                if (cnt == 2'd3) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, capture registers, beat counter and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            prio_load    <= 1'b1;
            fetch_rdata  <= '0;
            fetch_rvalid <= 1'b0;
            load_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_rvalid <= 1'b0;
            load_done    <= 1'b0;
            if (fetch_gnt || load_gnt) begin
                addr_q    <= load_gnt ? load_addr[AW-1:0] : fetch_addr[AW-1:0];
                cnt       <= 2'd0;
                prio_load <= fetch_gnt;
                if (load_gnt) wdata_q <= load_wdata;
            end else if (state != IDLE) begin
                cnt <= cnt + 2'd1;
            end
            if (state == FETCH) begin
                fetch_rdata[{cnt, 3'b000} +: 8] <= mem_rdata;
                if (cnt == 2'd3) fetch_rvalid <= 1'b1;
            end
            if (state == LOAD && cnt == 2'd3) load_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized scoreboard bench for imem_port_arbiter with a transaction-level
// reference model of arbitration, memory contents and pulse timing.
module tb_imem_port_arbiter;

    localparam int unsigned MSZ = 131072;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        load_req = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_wdata = '0;
    logic        load_gnt, load_done;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem     [0:MSZ-1];
    logic [7:0]  ref_mem [0:MSZ-1];

    int checks = 0;
    int errors = 0;

    imem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_done(load_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide storage array with combinational read.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 fetch, 2 load; pulse 1 rvalid, 2 done.
    int          m_kind = 0;
    int          m_beat = 0;
    int          m_pulse = 0;
    bit          m_prio_load = 1'b1;
    logic [16:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_last_word = '0;
    logic [31:0] fetch_q[$];

    initial begin : monitor
        logic [16:0] ea;
        logic [7:0]  ewd;
        logic [31:0] w;
        bit          eg_f, eg_l;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ea  = (m_kind != 0) ? 17'(m_addr + 17'(m_beat)) : 17'd0;
            ewd = (m_kind == 2) ? m_wdata[8*m_beat +: 8] : 8'd0;
            check("mem_bus", {38'd0, mem_addr, mem_we, mem_wdata},
                  {38'd0, ea, (m_kind == 2), ewd});
            eg_f = 1'b0;
            eg_l = 1'b0;
            if (m_kind == 0 && !rst) begin
                if (load_req && (!fetch_req || m_prio_load)) eg_l = 1'b1;
                else if (fetch_req) eg_f = 1'b1;
            end
            check("grants", {62'd0, fetch_gnt, load_gnt}, {62'd0, eg_f, eg_l});
            check("pulses", {62'd0, fetch_rvalid, load_done},
                  {62'd0, (m_pulse == 1), (m_pulse == 2)});
            if (fetch_rvalid === 1'b1) begin
                if (fetch_q.size() == 0) begin
                    check("rvalid_unexpected", 64'd1, 64'd0);
                end else begin
                    w = fetch_q.pop_front();
                    check("fetch_rdata", 64'(fetch_rdata), 64'(w));
                    m_last_word = w;
                end
            end else if (m_kind != 1) begin
                check("rdata_hold", 64'(fetch_rdata), 64'(m_last_word));
            end
            // Advance the model to the next cycle.
            if (m_kind == 2) ref_mem[ea] = ewd;
            if (rst) begin
                m_kind = 0; m_beat = 0; m_pulse = 0; m_prio_load = 1'b1;
                m_last_word = '0;
                fetch_q.delete();
            end else begin
                m_pulse = 0;
                if (m_kind != 0) begin
                    if (m_beat == 3) begin
                        m_pulse = m_kind;
                        m_kind = 0;
                    end else begin
                        m_beat++;
                    end
                end else if (eg_f || eg_l) begin
                    m_kind = eg_l ? 2 : 1;
                    m_beat = 0;
                    m_addr = eg_l ? load_addr[16:0] : fetch_addr[16:0];
                    m_wdata = load_wdata;
                    m_prio_load = eg_f;
                    if (eg_f) begin
                        for (int i = 0; i < 4; i++)
                            w[8*i +: 8] = ref_mem[17'(m_addr + 17'(i))];
                        fetch_q.push_back(w);
                    end
                end
            end
        end
    end

    // Raise requests and hold each until its grant is observed.
    task automatic issue(input bit df, input bit dl, input logic [31:0] fa,
                         input logic [31:0] la, input logic [31:0] ld);
        bit fp, lp, gf, gl;
        int n;
        @(posedge clk); #1;
        if (df) begin fetch_req = 1'b1; fetch_addr = fa; end
        if (dl) begin load_req = 1'b1; load_addr = la; load_wdata = ld; end
        fp = df; lp = dl; n = 0;
        while ((fp || lp) && n < 40) begin
            @(negedge clk);
            gf = fetch_gnt; gl = load_gnt;
            @(posedge clk); #1;
            if (gf) begin fetch_req = 1'b0; fp = 1'b0; end
            if (gl) begin load_req = 1'b0; lp = 1'b0; end
            n++;
        end
        if (fp || lp) begin
            check("grant_timeout", 64'd1, 64'd0);
            fetch_req = 1'b0; load_req = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] addrs [0:5];
        int          n;
        for (int i = 0; i < int'(MSZ); i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0001_FFFE; addrs[2] = 32'hFFFE_0101;
        addrs[3] = 32'h0000_0300; addrs[4] = 32'h0001_FFFD; addrs[5] = 32'h0000_0102;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b0, 1'b1, '0, 32'h0000_0100, 32'hDEAD_BEEF);
        settle();
        issue(1'b1, 1'b0, 32'h0000_0100, '0, '0);
        settle();

        // Continuous contention from both ports.
        @(posedge clk); #1;
        fetch_req = 1'b1; fetch_addr = 32'h0000_0200;
        load_req = 1'b1; load_addr = 32'h0000_0200; load_wdata = $urandom;
        repeat (22) @(posedge clk);
        #1 fetch_req = 1'b0; load_req = 1'b0;
        settle();

        issue(1'b0, 1'b1, '0, 32'h0001_FFFE, 32'h1122_3344);
        settle();
        issue(1'b1, 1'b0, 32'h0001_FFFE, '0, '0);
        settle();
        issue(1'b1, 1'b0, 32'hFFFE_0101, '0, '0);
        settle();

        // Reset during the second beat of a load, with a load pending across reset.
        issue(1'b0, 1'b1, '0, 32'h0000_0300, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst = 1'b1;
        load_req = 1'b1; load_addr = 32'h0000_0400; load_wdata = 32'h0BAD_C0DE;
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        while (load_gnt !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("post_reset_grant_wait", 64'(n), 64'd1);
        @(posedge clk); #1 load_req = 1'b0;
        settle();
        issue(1'b1, 1'b0, 32'h0000_0300, '0, '0);
        settle();

        // Fetch request pulsed while a load is busy.
        issue(1'b0, 1'b1, '0, 32'h0000_0500, 32'h5555_AAAA);
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 32'h0000_0500;
        @(posedge clk); #1 fetch_req = 1'b0;
        settle();

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom : addrs[$urandom_range(0, 5)],
                  addrs[$urandom_range(0, 5)], $urandom);
            if ($urandom_range(0, 1) == 1) settle();
        end
        repeat (12) @(posedge clk);
        check("fetch_queue_drained", 64'(fetch_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
